// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Operations are issued into S1 (drives the ALU). The ALU result is captured
// into S2, and the response is returned to the requester that issued it.
module alu_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    // requester side
    input  logic        reqValid0,
    input  logic        reqValid1,
    output logic        reqReady0,
    output logic        reqReady1,
    input  logic [31:0] A0,
    input  logic [31:0] A1,
    input  logic [31:0] B0,
    input  logic [31:0] B1,
    input  logic [3:0]  aluOp0,
    input  logic [3:0]  aluOp1,
    // response side
    output logic        rspValid0,
    output logic        rspValid1,
    input  logic        rspReady0,
    input  logic        rspReady1,
    output logic [31:0] rspRes,
    // shared ALU
    output logic [31:0] aluA,
    output logic [31:0] aluB,
    output logic [3:0]  aluOpOut,
    input  logic [31:0] aluRes
);

    // priority pointer: requester that wins when both are valid
    logic        ptr_q, ptr_d;

    // S1: issue stage
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_a_q, s1_a_d;
    logic [31:0] s1_b_q, s1_b_d;
    logic [3:0]  s1_op_q, s1_op_d;
    logic        s1_id_q, s1_id_d;

    // S2: result stage
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_res_q, s2_res_d;
    logic        s2_id_q, s2_id_d;

    logic        rsp_fire;
    logic        s2_accept;
    logic        s1_advance;
    logic        s1_accept;
    logic        gnt_id;
    logic        req_fire;

    // Handshake decode and outputs; rst masks everything the outside sees.
    always_comb begin
        rsp_fire   = s2_valid_q & (s2_id_q ? rspReady1 : rspReady0) & ~rst;
        s2_accept  = ~s2_valid_q | rsp_fire;
        s1_advance = s1_valid_q & s2_accept;
        s1_accept  = ~s1_valid_q | s1_advance;
        // single valid requester wins outright; the pointer only breaks ties
        gnt_id     = (reqValid0 & reqValid1) ? ptr_q : reqValid1;
        req_fire   = (reqValid0 | reqValid1) & s1_accept & ~rst;

        reqReady0  = req_fire & ~gnt_id;
        reqReady1  = req_fire &  gnt_id;

        rspValid0  = s2_valid_q & ~s2_id_q & ~rst;
        rspValid1  = s2_valid_q &  s2_id_q & ~rst;
        rspRes     = (s2_valid_q & ~rst) ? s2_res_q : 32'd0;

        aluA       = (s1_valid_q & ~rst) ? s1_a_q  : 32'd0;
        aluB       = (s1_valid_q & ~rst) ? s1_b_q  : 32'd0;
        aluOpOut   = (s1_valid_q & ~rst) ? s1_op_q : 4'd0;
    end

    // Next-state for both stages and the pointer.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_id_d    = s2_id_q;

        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = aluRes;
                s2_id_d  = s1_id_q;
            end
        end

        if (s1_accept) begin
            s1_valid_d = req_fire;
            if (req_fire) begin
                s1_a_d  = gnt_id ? A1 : A0;
                s1_b_d  = gnt_id ? B1 : B0;
                s1_op_d = gnt_id ? aluOp1 : aluOp0;
                s1_id_d = gnt_id;
            end
        end

        if (req_fire) begin
            ptr_d = ~gnt_id;
        end
    end

    // Control state: valid bits and pointer, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q      <= RR_INIT;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage payloads, qualified by the valid bits above.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are deliberately not reset; their valid bit
        // is reset and every output that exposes them is masked by it.
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_op_q  <= s1_op_d;
        s1_id_q  <= s1_id_d;
        s2_res_q <= s2_res_d;
        s2_id_q  <= s2_id_d;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, giving the requester that holds priority after reset (0 or 1).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have ports reqValid0/reqValid1  input  1 each  requester has an operation offered.
REQ-005 The block SHALL have ports reqReady0/reqReady1  output  1 each  operation accepted this cycle when valid&ready.
REQ-006 The block SHALL have ports A0/A1, B0/B1  input  32 each, and aluOp0/aluOp1  input  4 each  operands and ALU opcode per requester.
REQ-007 The block SHALL have ports rspValid0/rspValid1  output  1 each, rspReady0/rspReady1  input  1 each, and rspRes  output  32  result and handshake.
REQ-008 The block SHALL have ports aluA/aluB  output  32, aluOpOut  output  4, and aluRes  input  32, which connect to the single shared combinational ALU.

Function
REQ-009 The pipeline SHALL have two stages: issue register S1 (valid, A, B, op, id) and result register S2 (valid, res, id).
REQ-010 aluA, aluB, aluOpOut SHALL be driven directly from S1; when S1 is empty they SHALL be 0/0/4'b0000.
REQ-011 S2 SHALL capture aluRes and the S1 id on any cycle when S1 is valid and S2 can accept.
REQ-012 S2 can accept when S2 is empty or its response is consumed that cycle.
REQ-013 S1 can accept when S1 is empty or S1 advances into S2 that cycle.
REQ-014 Grant: when only one reqValid is high, that requester SHALL be granted; when both are high, the requester indicated by the priority pointer SHALL be granted.
REQ-015 reqReadyN SHALL be high only when N is granted and S1 can accept; the other reqReady SHALL be low that cycle.
REQ-016 reqReady SHALL be computed combinationally from reqValid, the pointer and stage state, with no dependence on the operand or opcode inputs.
REQ-017 On an accepted transfer from requester N, the pointer SHALL move to the other requester on the next cycle; otherwise it SHALL hold.
REQ-018 Latency: an operation accepted at cycle T SHALL present rspValidN at T+2 if there is no back-pressure.
REQ-019 Throughput: with rspReady held high, one operation per cycle SHALL be sustained.
REQ-020 rspValidN SHALL be high when S2 is valid and S2.id==N; the other rspValid SHALL be low.
REQ-021 rspRes SHALL equal S2.res while S2 is valid and SHALL be 0 when S2 is empty.
REQ-022 A response SHALL be consumed only when rspValidN and rspReadyN are both high; rspReady of the non-addressed requester SHALL be ignored.
REQ-023 While a response is stalled, S2 SHALL hold its contents, rspRes SHALL stay stable, S1 SHALL hold its contents, and aluA/aluB/aluOpOut SHALL stay stable.
REQ-024 The opcode SHALL be passed through unmodified, including undefined codes, so that the ALU result for an undefined code (0) is returned as a normal response.
REQ-025 No operation SHALL be dropped, duplicated or reordered: responses SHALL return in acceptance order across both requesters.
REQ-026 When a response is consumed and a new operation is accepted in the same cycle, both SHALL complete with no bubble.

Reset
REQ-027 When rst is high at a rising edge, S1.valid and S2.valid SHALL clear and the pointer SHALL load RR_INIT.
REQ-028 During and directly after reset, all reqReady and rspValid SHALL be 0, rspRes 0, and aluA/aluB/aluOpOut 0.
REQ-029 Asserting rst mid-operation SHALL discard in-flight operations with no response issued; rst SHALL take priority over any handshake in the same cycle.
REQ-030 The first cycle after rst deasserts SHALL allow acceptance (reqReady may be high).

Verification
REQ-031 Single op: req0 A=5 B=3 op=0000 at T, rspReady0=1 -> rspValid0 at T+2, rspRes=8, rspValid1=0.
REQ-032 Contention: both valid every cycle, req0 op=1000 A=10 B=4, req1 op=0001 A=1 B=4, RR_INIT=0 -> grants alternate 0,1,0,1; responses alternate 6,16.
REQ-033 Back-pressure: issue req1 op=1101 A=0x80000000 B=4, then req0 op=0111 A=0xFF B=0x0F, with rspReady1=0 for 3 cycles -> rspRes holds 0xF8000000, reqReady0 drops once S1 is full, then 0x0000000F follows in order with no loss.
REQ-034 Opcodes: op=0010 A=-1 B=1 -> 1; op=0011 A=-1 B=1 -> 0; undefined op=1111 -> rspRes=0 with rspValid high.
REQ-035 Reset mid-flight: accept two ops, assert rst at T+1 -> no rspValid ever for them; pointer=RR_INIT; new op accepted on the first post-reset cycle completes normally.
REQ-036 Streaming: 100 random ops, random valid/ready on both sides -> scoreboard matches every result in order, and no cycle has both reqReady or both rspValid high.
